// File: rtl/mult_axi_master_if.sv
// Bus bundle between mult_axi_master and its environment: command/result
// handshakes on the user side and the AXI-lite channels towards the
// multiplier slave.
interface mult_axi_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3
) ();

  // command side
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [DATA_WIDTH-1:0]   cmd_a;
  logic [DATA_WIDTH-1:0]   cmd_b;

  // result side
  logic                    res_valid;
  logic                    res_ready;
  logic [DATA_WIDTH-1:0]   res_product;
  logic                    res_overflow;
  logic                    res_err;

  // AXI-lite write address / data / response
  logic [ADDR_WIDTH-1:0]   m2_axi_awaddr;
  logic                    m2_axi_awvalid;
  logic                    m2_axi_awready;
  logic [DATA_WIDTH-1:0]   m2_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m2_axi_wstrb;
  logic                    m2_axi_wvalid;
  logic                    m2_axi_wready;
  logic [RESP_WIDTH-1:0]   m2_axi_bresp;
  logic                    m2_axi_bvalid;
  logic                    m2_axi_bready;

  // AXI-lite read address / data
  logic [ADDR_WIDTH-1:0]   m2_axi_araddr;
  logic                    m2_axi_arvalid;
  logic                    m2_axi_arready;
  logic [DATA_WIDTH-1:0]   m2_axi_rdata;
  logic [RESP_WIDTH-1:0]   m2_axi_rresp;
  logic                    m2_axi_rvalid;
  logic                    m2_axi_rready;

  // the AXI master block itself
  modport master (
    input  cmd_valid, cmd_a, cmd_b,
    output cmd_ready,
    output res_valid, res_product, res_overflow, res_err,
    input  res_ready,
    output m2_axi_awaddr, m2_axi_awvalid,
    input  m2_axi_awready,
    output m2_axi_wdata, m2_axi_wstrb, m2_axi_wvalid,
    input  m2_axi_wready,
    input  m2_axi_bresp, m2_axi_bvalid,
    output m2_axi_bready,
    output m2_axi_araddr, m2_axi_arvalid,
    input  m2_axi_arready,
    input  m2_axi_rdata, m2_axi_rresp, m2_axi_rvalid,
    output m2_axi_rready
  );

  // the environment: command source, result sink and AXI slave
  modport slave (
    output cmd_valid, cmd_a, cmd_b,
    input  cmd_ready,
    input  res_valid, res_product, res_overflow, res_err,
    output res_ready,
    input  m2_axi_awaddr, m2_axi_awvalid,
    output m2_axi_awready,
    input  m2_axi_wdata, m2_axi_wstrb, m2_axi_wvalid,
    output m2_axi_wready,
    output m2_axi_bresp, m2_axi_bvalid,
    input  m2_axi_bready,
    input  m2_axi_araddr, m2_axi_arvalid,
    output m2_axi_arready,
    output m2_axi_rdata, m2_axi_rresp, m2_axi_rvalid,
    input  m2_axi_rready
  );

endinterface

// File: rtl/mult_axi_master.sv
// AXI-lite master driving a memory-mapped multiplier: writes operand A and B,
// reads back the product low word and the overflow flag, then presents the
// result on a valid/ready port. One command in flight; every channel wait is
// bounded by a watchdog that aborts the command with res_err.
module mult_axi_master #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int RESP_WIDTH  = 3,
  parameter int WDOG_CYCLES = 16
) (
  input  logic           m2_axi_aclk,
  input  logic           m2_axi_aresetn,
  mult_axi_master_if.master bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(WDOG_CYCLES + 1);

  localparam logic [ADDR_WIDTH-1:0] ADDR_A   = ADDR_WIDTH'(16);
  localparam logic [ADDR_WIDTH-1:0] ADDR_B   = ADDR_WIDTH'(20);
  localparam logic [ADDR_WIDTH-1:0] ADDR_P   = ADDR_WIDTH'(24);
  localparam logic [ADDR_WIDTH-1:0] ADDR_O   = ADDR_WIDTH'(28);
  localparam logic [CNT_W-1:0]      WDOG_MAX = CNT_W'(WDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR_A = 3'd1,
    WR_B = 3'd2,
    RD_P = 3'd3,
    RD_O = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t                  state_q, state_nxt;

  // per-state handshake progress; cleared whenever the state changes
  logic                    aw_done_q, w_done_q, ar_done_q;
  logic [CNT_W-1:0]        wdog_cnt_q;
  logic                    rst_done_q;

  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic [DATA_WIDTH-1:0]   res_product_q;
  logic                    res_overflow_q;
  logic                    res_err_q;

  // combinational bus drive
  logic                    cmd_ready_c;
  logic                    awvalid_c, wvalid_c, bready_c, arvalid_c, rready_c;
  logic [ADDR_WIDTH-1:0]   awaddr_c, araddr_c;
  logic [DATA_WIDTH-1:0]   wdata_c;
  logic [STRB_W-1:0]       wstrb_c;
  logic                    res_valid_c;

  // handshake / event decode
  logic                    in_wr, in_rd;
  logic                    cmd_acc, aw_hs, w_hs, ar_hs;
  logic                    wr_cmpl, rd_cmpl, wdog_hit;
  logic                    b_err, r_err;

  assign in_wr    = (state_q == WR_A) || (state_q == WR_B);
  assign in_rd    = (state_q == RD_P) || (state_q == RD_O);
  assign cmd_acc  = bus.cmd_valid & cmd_ready_c;
  assign aw_hs    = awvalid_c & bus.m2_axi_awready;
  assign w_hs     = wvalid_c & bus.m2_axi_wready;
  assign ar_hs    = arvalid_c & bus.m2_axi_arready;
  // a B response counts once both AW and W have completed, including when the
  // last of them completes in this very cycle
  assign wr_cmpl  = in_wr & bus.m2_axi_bvalid &
                    (aw_done_q | aw_hs) & (w_done_q | w_hs);
  // the slave holds rvalid high from earlier reads, so only data seen after
  // the AR handshake cycle belongs to this read
  assign rd_cmpl  = in_rd & bus.m2_axi_rvalid & ar_done_q;
  // bready/rready are held for the whole of every bus state, so something is
  // always pending there; any handshake or completion this cycle re-arms it
  assign wdog_hit = (in_wr | in_rd) & (wdog_cnt_q == WDOG_MAX) &
                    ~aw_hs & ~w_hs & ~ar_hs & ~wr_cmpl & ~rd_cmpl;
  assign b_err    = (bus.m2_axi_bresp != '0);
  assign r_err    = (bus.m2_axi_rresp != '0);

  // state register
  always_ff @(posedge m2_axi_aclk or negedge m2_axi_aresetn) begin
    if (!m2_axi_aresetn) state_q <= IDLE;
    else                 state_q <= state_nxt;
  end

  // next-state decode: fixed walk IDLE->WR_A->WR_B->RD_P->RD_O->DONE, errors
  // and watchdog expiry short-cut to DONE
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (cmd_acc) state_nxt = WR_A;
      WR_A: begin
        if (wr_cmpl)       state_nxt = b_err ? DONE : WR_B;
        else if (wdog_hit) state_nxt = DONE;
      end
      WR_B: begin
        if (wr_cmpl)       state_nxt = b_err ? DONE : RD_P;
        else if (wdog_hit) state_nxt = DONE;
      end
      RD_P: begin
        if (rd_cmpl)       state_nxt = r_err ? DONE : RD_O;
        else if (wdog_hit) state_nxt = DONE;
      end
      RD_O: begin
        if (rd_cmpl || wdog_hit) state_nxt = DONE;
      end
      DONE: if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // output decode: valids/readies/addresses follow the state and progress flags
  always_comb begin
    cmd_ready_c = 1'b0;
    awvalid_c   = 1'b0;
    wvalid_c    = 1'b0;
    bready_c    = 1'b0;
    arvalid_c   = 1'b0;
    rready_c    = 1'b0;
    awaddr_c    = '0;
    araddr_c    = '0;
    wdata_c     = '0;
    wstrb_c     = '0;
    res_valid_c = 1'b0;
    case (state_q)
      IDLE: cmd_ready_c = rst_done_q;
      WR_A: begin
        awvalid_c = ~aw_done_q;
        wvalid_c  = ~w_done_q;
        bready_c  = 1'b1;
        awaddr_c  = ADDR_A;
        wdata_c   = a_q;
        wstrb_c   = '1;
      end
      WR_B: begin
        awvalid_c = ~aw_done_q;
        wvalid_c  = ~w_done_q;
        bready_c  = 1'b1;
        awaddr_c  = ADDR_B;
        wdata_c   = b_q;
        wstrb_c   = '1;
      end
      RD_P: begin
        arvalid_c = ~ar_done_q;
        rready_c  = 1'b1;
        araddr_c  = ADDR_P;
      end
      RD_O: begin
        arvalid_c = ~ar_done_q;
        rready_c  = 1'b1;
        araddr_c  = ADDR_O;
      end
      DONE: res_valid_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.cmd_ready      = cmd_ready_c;
  assign bus.m2_axi_awvalid = awvalid_c;
  assign bus.m2_axi_awaddr  = awaddr_c;
  assign bus.m2_axi_wvalid  = wvalid_c;
  assign bus.m2_axi_wdata   = wdata_c;
  assign bus.m2_axi_wstrb   = wstrb_c;
  assign bus.m2_axi_bready  = bready_c;
  assign bus.m2_axi_arvalid = arvalid_c;
  assign bus.m2_axi_araddr  = araddr_c;
  assign bus.m2_axi_rready  = rready_c;
  assign bus.res_valid      = res_valid_c;
  assign bus.res_product    = res_product_q;
  assign bus.res_overflow   = res_overflow_q;
  assign bus.res_err        = res_err_q;

  // handshake progress flags and watchdog, restarted on every state entry
  always_ff @(posedge m2_axi_aclk or negedge m2_axi_aresetn) begin
    if (!m2_axi_aresetn) begin
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      ar_done_q  <= 1'b0;
      wdog_cnt_q <= '0;
    end else if (state_nxt != state_q) begin
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      ar_done_q  <= 1'b0;
      wdog_cnt_q <= '0;
    end else begin
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (ar_hs) ar_done_q <= 1'b1;
      if (aw_hs || w_hs || ar_hs)
        wdog_cnt_q <= '0;
      else if ((in_wr || in_rd) && (wdog_cnt_q != WDOG_MAX))
        wdog_cnt_q <= wdog_cnt_q + 1'b1;
    end
  end

  // cmd_ready stays low until the first clock after reset release
  always_ff @(posedge m2_axi_aclk or negedge m2_axi_aresetn) begin
    if (!m2_axi_aresetn) rst_done_q <= 1'b0;
    else                 rst_done_q <= 1'b1;
  end

  // operand capture on command accept
  always_ff @(posedge m2_axi_aclk or negedge m2_axi_aresetn) begin
    if (!m2_axi_aresetn) begin
      a_q <= '0;
      b_q <= '0;
    end else if (cmd_acc) begin
      a_q <= bus.cmd_a;
      b_q <= bus.cmd_b;
    end
  end

  // result registers: product/overflow only move on an accepted read, so a
  // watchdog abort leaves the previous values in place
  always_ff @(posedge m2_axi_aclk or negedge m2_axi_aresetn) begin
    if (!m2_axi_aresetn) begin
      res_product_q  <= '0;
      res_overflow_q <= 1'b0;
      res_err_q      <= 1'b0;
    end else begin
      if (cmd_acc)
        res_err_q <= 1'b0;
      else if ((wr_cmpl && b_err) || (rd_cmpl && r_err) || wdog_hit)
        res_err_q <= 1'b1;
      if (rd_cmpl && (state_q == RD_P))
        res_product_q <= bus.m2_axi_rdata;
      if (rd_cmpl && (state_q == RD_O))
        res_overflow_q <= bus.m2_axi_rdata[0];
    end
  end

endmodule

// File: tb/tb_mult_axi_master.sv
// Bench for mult_axi_master: a behavioural AXI-lite multiplier slave with
// programmable ready delays, error responses and spurious early valids, and a
// directed/random command sequence checked against plain 64-bit arithmetic.
module tb_mult_axi_master;

  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int RW   = 3;
  localparam int WDOG = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_axi_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) bus ();

  mult_axi_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .WDOG_CYCLES(WDOG)
  ) dut (
    .m2_axi_aclk   (clk),
    .m2_axi_aresetn(rst_n),
    .bus           (bus)
  );

  // slave behaviour knobs (ar_dly of 255 means arready never rises)
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic [2:0]  bresp_cfg = 3'd0, rresp_cfg = 3'd0;
  bit          junk = 1'b0;

  // slave state
  int              aw_wait, w_wait, ar_wait;
  logic            got_aw, got_w;
  logic [AW-1:0]   aw_l;
  logic [DW-1:0]   w_l;
  logic            bvalid_q, rvalid_q;
  logic [RW-1:0]   bresp_q, rresp_q;
  logic [DW-1:0]   rdata_q;
  logic [DW-1:0]   mem_a, mem_b;
  logic [63:0]     prod;

  logic aw_hs, w_hs, ar_hs, ga, gw, junk_b, junk_r;
  logic [AW-1:0] addr_eff;
  logic [DW-1:0] data_eff;

  assign bus.m2_axi_awready = bus.m2_axi_awvalid && (aw_wait >= aw_dly);
  assign bus.m2_axi_wready  = bus.m2_axi_wvalid && (w_wait >= w_dly);
  assign bus.m2_axi_arready = bus.m2_axi_arvalid && (ar_dly < 255) && (ar_wait >= ar_dly);

  assign aw_hs    = bus.m2_axi_awvalid && bus.m2_axi_awready;
  assign w_hs     = bus.m2_axi_wvalid && bus.m2_axi_wready;
  assign ar_hs    = bus.m2_axi_arvalid && bus.m2_axi_arready;
  assign ga       = got_aw || aw_hs;
  assign gw       = got_w || w_hs;
  assign addr_eff = aw_hs ? bus.m2_axi_awaddr : aw_l;
  assign data_eff = w_hs ? bus.m2_axi_wdata : w_l;
  assign prod     = {32'd0, mem_a} * {32'd0, mem_b};

  // spurious responses that a correct master must ignore
  assign junk_b = junk && ((bus.m2_axi_awvalid && !bus.m2_axi_awready) ||
                           (bus.m2_axi_wvalid && !bus.m2_axi_wready));
  assign junk_r = junk && bus.m2_axi_arvalid;

  assign bus.m2_axi_bvalid = bvalid_q || junk_b;
  assign bus.m2_axi_bresp  = bvalid_q ? bresp_q : 3'd2;
  assign bus.m2_axi_rvalid = rvalid_q || junk_r;
  assign bus.m2_axi_rdata  = rvalid_q ? rdata_q : 32'hDEAD_BEEF;
  assign bus.m2_axi_rresp  = rvalid_q ? rresp_q : 3'd2;

  // multiplier slave: registers at 16/20, product low word at 24, overflow at 28
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; aw_l <= '0; w_l <= '0;
      bvalid_q <= 1'b0; bresp_q <= '0;
      rvalid_q <= 1'b0; rresp_q <= '0; rdata_q <= '0;
      mem_a <= '0; mem_b <= '0;
    end else begin
      aw_wait <= (bus.m2_axi_awvalid && !bus.m2_axi_awready) ? aw_wait + 1 : 0;
      w_wait  <= (bus.m2_axi_wvalid && !bus.m2_axi_wready) ? w_wait + 1 : 0;
      ar_wait <= (bus.m2_axi_arvalid && !bus.m2_axi_arready) ? ar_wait + 1 : 0;
      if (aw_hs) begin got_aw <= 1'b1; aw_l <= bus.m2_axi_awaddr; end
      if (w_hs)  begin got_w <= 1'b1;  w_l <= bus.m2_axi_wdata;  end
      if (ga && gw && !bvalid_q) begin
        bvalid_q <= 1'b1;
        bresp_q  <= bresp_cfg;
        got_aw   <= 1'b0;
        got_w    <= 1'b0;
        if (addr_eff == 8'd16)      mem_a <= data_eff;
        else if (addr_eff == 8'd20) mem_b <= data_eff;
      end else if (bvalid_q && bus.m2_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rresp_cfg;
        if (bus.m2_axi_araddr == 8'd24)      rdata_q <= prod[31:0];
        else if (bus.m2_axi_araddr == 8'd28) rdata_q <= {31'd0, (prod[63:32] != 32'd0)};
        else                                 rdata_q <= '0;
      end else if (rvalid_q && bus.m2_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // bus activity monitor
  logic          clr_mon = 1'b0;
  logic [AW-1:0] aw_log[$];
  logic [DW-1:0] w_log[$];
  logic [AW-1:0] ar_log[$];
  int            awa_hi, wa_hi, ba_cnt, ar_hi;

  always @(posedge clk) begin
    if (clr_mon) begin
      aw_log.delete(); w_log.delete(); ar_log.delete();
      awa_hi <= 0; wa_hi <= 0; ba_cnt <= 0; ar_hi <= 0;
    end else begin
      if (aw_hs) aw_log.push_back(bus.m2_axi_awaddr);
      if (w_hs)  w_log.push_back(bus.m2_axi_wdata);
      if (ar_hs) ar_log.push_back(bus.m2_axi_araddr);
      if (bus.m2_axi_awvalid && bus.m2_axi_awaddr == 8'd16) awa_hi <= awa_hi + 1;
      if (bus.m2_axi_wvalid && bus.m2_axi_awaddr == 8'd16)  wa_hi <= wa_hi + 1;
      if (bus.m2_axi_bvalid && bus.m2_axi_bready && bus.m2_axi_awaddr == 8'd16)
        ba_cnt <= ba_cnt + 1;
      if (bus.m2_axi_arvalid) ar_hi <= ar_hi + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clk); clr_mon = 1'b1;
    @(negedge clk); clr_mon = 1'b0;
  endtask

  task automatic set_slave(input int awd, input int wd, input int ard,
                           input logic [2:0] br, input logic [2:0] rr, input bit jk);
    aw_dly = awd; w_dly = wd; ar_dly = ard;
    bresp_cfg = br; rresp_cfg = rr; junk = jk;
  endtask

  // present one command and wait (bounded) for the result; lat counts cycles
  // after the accepting cycle until res_valid is seen
  task automatic run_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b, output int lat);
    int guard;
    @(negedge clk);
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_valid = 1'b1;
    guard = 0;
    while (!bus.cmd_ready && guard < 20) begin @(negedge clk); guard++; end
    check("cmd_accept", {63'd0, bus.cmd_ready}, 64'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 200) begin @(negedge clk); lat++; end
    check("res_valid_seen", {63'd0, bus.res_valid}, 64'd1);
  endtask

  // hold off res_ready for a cycle, then retire the result
  task automatic finish_cmd();
    logic [DW-1:0] p;
    logic o, e;
    p = bus.res_product; o = bus.res_overflow; e = bus.res_err;
    @(negedge clk);
    check("done_hold_valid", {63'd0, bus.res_valid}, 64'd1);
    check("done_hold_stable", {31'd0, bus.res_err, bus.res_overflow, bus.res_product},
                              {31'd0, e, o, p});
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("retire_valid_low", {63'd0, bus.res_valid}, 64'd0);
    check("retire_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
  endtask

  // full good-path checks for one command against the reference arithmetic
  task automatic good_cmd(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          output logic [DW-1:0] ep, output logic eo);
    int lat;
    logic [63:0] full;
    clear_mon();
    run_cmd(a, b, lat);
    full = {32'd0, a} * {32'd0, b};
    ep = full[31:0];
    eo = (full[63:32] != 32'd0);
    check({tag, "_product"}, {32'd0, bus.res_product}, {32'd0, ep});
    check({tag, "_overflow"}, {63'd0, bus.res_overflow}, {63'd0, eo});
    check({tag, "_err"}, {63'd0, bus.res_err}, 64'd0);
    check({tag, "_lat_ge9"}, {63'd0, (lat >= 9)}, 64'd1);
    check({tag, "_aw_seq"}, {32'(aw_log.size()), 16'd0, aw_log[0], aw_log[1]},
                            {32'd2, 16'd0, 8'd16, 8'd20});
    check({tag, "_w_data"}, {w_log[0], w_log[1]}, {a, b});
    check({tag, "_ar_seq"}, {32'(ar_log.size()), 16'd0, ar_log[0], ar_log[1]},
                            {32'd2, 16'd0, 8'd24, 8'd28});
    finish_cmd();
  endtask

  initial begin : watchdog_global
    #400000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    logic [DW-1:0] last_p, ep, a, b;
    logic last_o, eo;
    int lat, guard;

    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.res_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
    check("rst_valids", {59'd0, bus.m2_axi_awvalid, bus.m2_axi_wvalid, bus.m2_axi_bready,
                         bus.m2_axi_arvalid, bus.m2_axi_rready}, 64'd0);
    check("rst_results", {30'd0, bus.res_valid, bus.res_err, bus.res_overflow, bus.res_product},
                         64'd0);
    check("rst_addr_data", {bus.m2_axi_wdata, 16'd0, bus.m2_axi_awaddr, bus.m2_axi_araddr}, 64'd0);
    rst_n = 1'b1;
    #1 check("rel_cmd_ready_pre_clk", {63'd0, bus.cmd_ready}, 64'd0);
    @(negedge clk);
    check("rel_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);

    // basic and overflow cases with a zero-wait slave
    set_slave(0, 0, 0, 3'd0, 3'd0, 1'b0);
    good_cmd("c3x5", 32'd3, 32'd5, ep, eo);
    check("c3x5_ref", {31'd0, eo, ep}, 64'd15);
    good_cmd("c_ovf", 32'h0001_0000, 32'h0001_0000, ep, eo);
    check("c_ovf_ref", {31'd0, eo, ep}, {31'd0, 1'b1, 32'd0});

    // AW held off three cycles, W accepted at once
    set_slave(3, 0, 0, 3'd0, 3'd0, 1'b0);
    good_cmd("aw_dly3", 32'd11, 32'd13, ep, eo);
    check("aw_dly3_aw_cycles", 64'(awa_hi), 64'd4);
    check("aw_dly3_w_cycles", 64'(wa_hi), 64'd1);
    check("aw_dly3_b_count", 64'(ba_cnt), 64'd1);

    // random operands, random slave timing, spurious early responses
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : DW'($urandom_range(0, 65535));
      set_slave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                3'd0, 3'd0, 1'($urandom_range(0, 1)));
      good_cmd("rand", a, b, ep, eo);
    end

    // read error on the product read
    set_slave(0, 0, 0, 3'd0, 3'd2, 1'b0);
    clear_mon();
    run_cmd(32'd4, 32'd4, lat);
    check("rresp_err", {63'd0, bus.res_err}, 64'd1);
    check("rresp_ar_count", 64'(ar_log.size()), 64'd1);
    finish_cmd();

    // restore a known result for the hold checks below
    set_slave(0, 0, 0, 3'd0, 3'd0, 1'b0);
    good_cmd("known", 32'h8000_0001, 32'd6, last_p, last_o);

    // write error on operand A
    set_slave(0, 0, 0, 3'd2, 3'd0, 1'b0);
    clear_mon();
    run_cmd(32'd9, 32'd9, lat);
    check("bresp_err", {62'd0, bus.res_err, bus.res_valid}, 64'd3);
    check("bresp_aw_only_a", {32'(aw_log.size()), 24'd0, aw_log[0]}, {32'd1, 24'd0, 8'd16});
    check("bresp_no_ar", 64'(ar_log.size()), 64'd0);
    check("bresp_hold", {31'd0, bus.res_overflow, bus.res_product}, {31'd0, last_o, last_p});
    finish_cmd();

    // AR never accepted: watchdog abort
    set_slave(0, 0, 255, 3'd0, 3'd0, 1'b0);
    clear_mon();
    run_cmd(32'd2, 32'd2, lat);
    check("wdog_err", {62'd0, bus.res_err, bus.res_valid}, 64'd3);
    check("wdog_arvalid_low", {63'd0, bus.m2_axi_arvalid}, 64'd0);
    check("wdog_ar_cycles", 64'(ar_hi), 64'(WDOG));
    check("wdog_hold", {31'd0, bus.res_overflow, bus.res_product}, {31'd0, last_o, last_p});
    finish_cmd();

    // reset pulsed while the overflow read is waiting for arready
    set_slave(0, 0, 3, 3'd0, 3'd0, 1'b0);
    clear_mon();
    @(negedge clk);
    bus.cmd_a = 32'd9; bus.cmd_b = 32'd9; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    guard = 0;
    while (!(bus.m2_axi_arvalid && bus.m2_axi_araddr == 8'd28) && guard < 100) begin
      @(negedge clk); guard++;
    end
    check("rdo_reached", {63'd0, bus.m2_axi_arvalid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_arvalid", {63'd0, bus.m2_axi_arvalid}, 64'd0);
    check("midrst_res_valid", {63'd0, bus.res_valid}, 64'd0);
    check("midrst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
    check("postrst_no_result", {63'd0, bus.res_valid}, 64'd0);
    set_slave(0, 0, 0, 3'd0, 3'd0, 1'b0);
    good_cmd("c7x6", 32'd7, 32'd6, ep, eo);
    check("c7x6_ref", {32'd0, ep}, 64'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_axi_master.md
MULT_AXI_MASTER -- requirements
Module: mult_axi_master

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, data/operand width; ADDR_WIDTH, 8, AXI address width; RESP_WIDTH, 3, response width; WDOG_CYCLES, 16, maximum wait per channel handshake.
REQ-002 Ports SHALL be:
- m2_axi_aclk  in  1  single clock; all logic on rising edge.
- m2_axi_aresetn  in  1  reset, asynchronous, active-low.
- cmd_valid / cmd_ready  in / out  1 / 1  operand-pair handshake.
- cmd_a, cmd_b  in  DATA_WIDTH  operands.
- res_valid / res_ready  out / in  1 / 1  result handshake.
- res_product  out  DATA_WIDTH  product low word.
- res_overflow  out  1  overflow flag.
- res_err  out  1  bus error or watchdog abort.
- m2_axi_awaddr  out  ADDR_WIDTH;  m2_axi_awvalid out 1;  m2_axi_awready in 1.
- m2_axi_wdata  out  DATA_WIDTH;  m2_axi_wstrb out DATA_WIDTH/8;  m2_axi_wvalid out 1;  m2_axi_wready in 1.
- m2_axi_bresp  in  RESP_WIDTH;  m2_axi_bvalid in 1;  m2_axi_bready out 1.
- m2_axi_araddr  out  ADDR_WIDTH;  m2_axi_arvalid out 1;  m2_axi_arready in 1.
- m2_axi_rdata  in  DATA_WIDTH;  m2_axi_rresp in RESP_WIDTH;  m2_axi_rvalid in 1;  m2_axi_rready out 1.

Function
REQ-003 The block SHALL be an AXI-lite master that drives the downstream multiplier slave: write operand A to 16, operand B to 20, read product at 24, read overflow at 28.
REQ-004 FSM states SHALL be IDLE, WR_A, WR_B, RD_P, RD_O, DONE, traversed in that order.
REQ-005 In IDLE: cmd_ready=1; on cmd_valid&cmd_ready, latch cmd_a/cmd_b, clear res_err and go to WR_A.
REQ-006 In WR_x: awvalid and wvalid SHALL assert in the same cycle as entry, with awaddr=16 (WR_A) or 20 (WR_B), wdata=latched operand, wstrb all ones.
REQ-007 awvalid SHALL deassert the cycle after awvalid&awready; wvalid SHALL deassert the cycle after wvalid&wready. Each drops independently; neither reasserts within the same write.
REQ-008 bready SHALL be 1 throughout WR_x, including while awvalid/wvalid are high.
REQ-009 The write SHALL complete on the first bvalid&bready cycle at or after the cycle in which both the AW and W handshakes have completed. bvalid before that point SHALL be ignored.
REQ-010 bresp!=0 at completion SHALL set res_err and go to DONE. Otherwise WR_A goes to WR_B, and WR_B goes to RD_P.
REQ-011 In RD_x: arvalid=1 with araddr=24 (RD_P) or 28 (RD_O). rready SHALL be 1 throughout RD_x, including while arvalid is high.
REQ-012 arvalid SHALL deassert the cycle after arvalid&arready.
REQ-013 Read data SHALL be accepted only on an rvalid&rready cycle strictly after the AR handshake cycle. Earlier rvalid SHALL be ignored, because the slave's rvalid is sticky.
REQ-014 On acceptance:
- RD_P captures rdata into res_product.
- RD_O captures rdata[0] into res_overflow.
- rresp!=0 sets res_err and goes to DONE.
- Otherwise RD_P goes to RD_O, and RD_O goes to DONE.
REQ-015 In DONE: res_valid=1, outputs stable; on res_ready, go to IDLE (res_valid=0 next cycle).
REQ-016 Watchdog: a counter SHALL reset on each state entry and on each AW/W/AR handshake. If it reaches WDOG_CYCLES while any valid or ready is pending, the block SHALL drop all AXI valids, set res_err=1 and go to DONE. res_product/res_overflow then hold prior values.
REQ-017 Minimum latency with zero-wait slave: cmd accept to res_valid SHALL be no less than 9 cycles. No pipelining: one command in flight.

Reset
REQ-018 Asserting m2_axi_aresetn low SHALL immediately, without clock, force:
- state=IDLE;
- awvalid, wvalid, bready, arvalid, rready, res_valid, res_err, res_overflow = 0;
- res_product=0, addresses=0, wdata=0;
- cmd_ready=0 while in reset, 1 on the first clock after release.
Reset mid-transaction SHALL abandon the transaction with no completion reported.

Verification
REQ-019 a=3, b=5, zero-wait slave model -> writes 16←3, 20←5, reads 24, 28; res_product=15, res_overflow=0, res_err=0.
REQ-020 a=0x00010000, b=0x00010000 -> res_product=0x00000000, res_overflow=1.
REQ-021 awready delayed 3 cycles, wready immediate on WR_A -> wvalid high 1 cycle, awvalid high 4 cycles, single B accepted, then WR_B.
REQ-022 bresp=2 on WR_A -> res_err=1, res_valid=1, no AW on address 20 and no AR issued.
REQ-023 Slave never asserts arready in RD_P -> after WDOG_CYCLES, arvalid=0, res_err=1, res_valid=1.
REQ-024 Reset pulsed low during RD_O with arvalid=1 -> arvalid=0 and res_valid=0 within the same cycle; after release cmd_ready=1 and a new a=7, b=6 yields 42.
